// File: rtl/dot_pkg.sv
// Shared types for the dot-product accelerator and its stream driver.
// Latency: none (types, constants and helpers only).
// Backpressure: not applicable.
package dot_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for an n-entry buffer; at least one bit so ports stay legal when n == 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dot_rx_capture.sv
// Receiver end of the accelerator output stream: counts words, fills the result buffer, checks TLAST framing.
// Latency: a word is written into the buffer on its handshake edge; the read port is combinational.
// Backpressure: tready is high only while running and fewer than ROWS words have been taken.
module dot_rx_capture
  import dot_pkg::*;
#(
  parameter int ROWS = 3,
  localparam int RA_W = idx_w(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tlast,
  input  logic              tvalid,
  output logic              tready,
  output logic              rx_complete,
  output logic              err,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CW = $clog2(ROWS + 1);

  logic [CW-1:0]     rx_cnt;
  logic [DATA_W-1:0] result [ROWS];
  logic              fire;
  logic              last_slot;
  logic              frame_bad;

  assign tready    = run && (rx_cnt < CW'(ROWS));
  assign fire      = tvalid && tready;
  assign last_slot = (rx_cnt == CW'(ROWS - 1));
  // TLAST must be set on exactly the final word of the packet; any other placement is a framing error.
  assign frame_bad = fire && (tlast != last_slot);
  // Counts the word being accepted this cycle so the FSM can leave RUN without an extra cycle.
  assign rx_complete = (rx_cnt == CW'(ROWS)) || (fire && last_slot);

  // Word counter, result capture and sticky framing error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_cnt <= '0;
      err    <= 1'b0;
      for (int i = 0; i < ROWS; i++) result[i] <= '0;
    end else if (clear) begin
      rx_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (fire) begin
        rx_cnt <= rx_cnt + CW'(1);
        for (int i = 0; i < ROWS; i++) begin
          if (rx_cnt == CW'(i)) result[i] <= tdata;
        end
      end
      if (frame_bad) err <= 1'b1;
    end
  end

  // Host read port; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (rd_addr == RA_W'(i)) rd_data = result[i];
    end
  end

endmodule

// File: rtl/dot_stream_driver.sv
// Host-side stream driver: sends a COLS-word vector to the accelerator and captures its ROWS-word result.
// Latency: start in cycle 0 -> first word valid in cycle 1; done one cycle after the last tx/rx handshake.
// Backpressure: tx words are held stable until OUTPUT_AXIS_TREADY; rx stops accepting after ROWS words.
module dot_stream_driver
  import dot_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 3,
  localparam int VA_W = idx_w(COLS),
  localparam int RA_W = idx_w(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vec_wr_en,
  input  logic [VA_W-1:0]   vec_wr_addr,
  input  logic [DATA_W-1:0] vec_wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [RA_W-1:0]   res_rd_addr,
  output logic [DATA_W-1:0] res_rd_data,
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
  input  logic              INPUT_AXIS_TLAST,
  input  logic              INPUT_AXIS_TVALID,
  output logic              INPUT_AXIS_TREADY
);

  localparam int TW = $clog2(COLS + 1);

  state_t            state;
  logic [DATA_W-1:0] vec [COLS];
  logic [TW-1:0]     tx_cnt;
  logic [TW-1:0]     nxt;
  logic [DATA_W-1:0] next_word;
  logic              tx_fire;
  logic              tx_last_word;
  logic              tx_complete;
  logic              rx_complete;
  logic              start_ok;

  assign start_ok     = (state == IDLE) && start;
  assign nxt          = tx_cnt + TW'(1);
  assign tx_fire      = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;
  assign tx_last_word = (tx_cnt == TW'(COLS - 1));
  // Includes the final handshake of this cycle so tx and rx may finish together.
  assign tx_complete  = (tx_cnt == TW'(COLS)) || (tx_fire && tx_last_word);

  // Vector buffer: host writes land only while idle so an in-flight packet is never altered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < COLS; i++) vec[i] <= '0;
    end else if ((state == IDLE) && vec_wr_en) begin
      for (int i = 0; i < COLS; i++) begin
        if (vec_wr_addr == VA_W'(i)) vec[i] <= vec_wr_data;
      end
    end
  end

  // Word that follows the one currently on the bus.
  always_comb begin
    next_word = '0;
    for (int i = 0; i < COLS; i++) begin
      if (nxt == TW'(i)) next_word = vec[i];
    end
  end

  // Transaction FSM with registered transmitter and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      tx_cnt             <= '0;
      OUTPUT_AXIS_TDATA  <= '0;
      OUTPUT_AXIS_TLAST  <= 1'b0;
      OUTPUT_AXIS_TVALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state              <= RUN;
            busy               <= 1'b1;
            tx_cnt             <= '0;
            OUTPUT_AXIS_TDATA  <= vec[0];
            OUTPUT_AXIS_TLAST  <= (COLS == 1);
            OUTPUT_AXIS_TVALID <= 1'b1;
          end
        end
        RUN: begin
          if (tx_fire) begin
            tx_cnt <= nxt;
            if (tx_last_word) begin
              OUTPUT_AXIS_TVALID <= 1'b0;
              OUTPUT_AXIS_TLAST  <= 1'b0;
            end else begin
              OUTPUT_AXIS_TDATA <= next_word;
              OUTPUT_AXIS_TLAST <= (nxt == TW'(COLS - 1));
            end
          end
          if (tx_complete && rx_complete) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dot_rx_capture #(
    .ROWS(ROWS)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok),
    .run         (state == RUN),
    .tdata       (INPUT_AXIS_TDATA),
    .tlast       (INPUT_AXIS_TLAST),
    .tvalid      (INPUT_AXIS_TVALID),
    .tready      (INPUT_AXIS_TREADY),
    .rx_complete (rx_complete),
    .err         (err),
    .rd_addr     (res_rd_addr),
    .rd_data     (res_rd_data)
  );

endmodule

// File: tb/tb_dot_stream_driver.sv
// Directed bench for dot_stream_driver with COLS=4, ROWS=3.
// Drives inputs 1 time unit after the rising edge and samples outputs there.
// Every expected value below is computed by hand from the cycle numbering of the protocol.
module tb_dot_stream_driver;

  localparam int COLS = 4;
  localparam int ROWS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        vec_wr_en;
  logic [1:0]  vec_wr_addr;
  logic [31:0] vec_wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  res_rd_addr;
  logic [31:0] res_rd_data;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dot_stream_driver #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .vec_wr_en          (vec_wr_en),
    .vec_wr_addr        (vec_wr_addr),
    .vec_wr_data        (vec_wr_data),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .res_rd_addr        (res_rd_addr),
    .res_rd_data        (res_rd_data),
    .OUTPUT_AXIS_TDATA  (o_tdata),
    .OUTPUT_AXIS_TLAST  (o_tlast),
    .OUTPUT_AXIS_TVALID (o_tvalid),
    .OUTPUT_AXIS_TREADY (o_tready),
    .INPUT_AXIS_TDATA   (i_tdata),
    .INPUT_AXIS_TLAST   (i_tlast),
    .INPUT_AXIS_TVALID  (i_tvalid),
    .INPUT_AXIS_TREADY  (i_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},   32'(busy),     32'd0);
    chk({tag, "_done"},   32'(done),     32'd0);
    chk({tag, "_err"},    32'(err),      32'd0);
    chk({tag, "_tvalid"}, 32'(o_tvalid), 32'd0);
    chk({tag, "_tlast"},  32'(o_tlast),  32'd0);
    chk({tag, "_tdata"},  o_tdata,       32'd0);
    chk({tag, "_irdy"},   32'(i_tready), 32'd0);
    res_rd_addr = 2'd0;
    #1;
    chk({tag, "_res0"},   res_rd_data,   32'd0);
  endtask

  task automatic write_vec();
    for (int i = 0; i < COLS; i++) begin
      vec_wr_en   = 1'b1;
      vec_wr_addr = 2'(i);
      vec_wr_data = 32'(i + 1);
      tick();
    end
    vec_wr_en = 1'b0;
  endtask

  task automatic send_rx(input logic [31:0] d, input logic last);
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = last;
    tick();
  endtask

  // One transaction with vector {1,2,3,4}; results are base+0..2; extra words are offered after the third.
  task automatic run_txn(input string tag, input int rdy_mode, input int rx_first,
                         input logic bad_last, input logic [31:0] base, input logic poke,
                         input logic exp_err, input int exp_done);
    int cyc;
    int tx_i;
    int rx_i;
    int done_cyc;
    o_tready = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    tx_i     = 0;
    rx_i     = 0;
    done_cyc = -1;
    chk({tag, "_err_cleared"}, 32'(err),  32'd0);
    chk({tag, "_busy_c1"},     32'(busy), 32'd1);
    while (cyc < 60 && done_cyc < 0) begin
      o_tready = (rdy_mode == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
      if (rx_i < ROWS && cyc >= rx_first) begin
        i_tvalid = 1'b1;
        i_tdata  = base + 32'(rx_i);
        i_tlast  = bad_last ? (rx_i == 1) : (rx_i == 2);
      end else if (rx_i >= ROWS) begin
        i_tvalid = 1'b1;
        i_tdata  = 32'hdead;
        i_tlast  = 1'b1;
      end else begin
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
      end
      if (poke) begin
        vec_wr_en   = (cyc == 2);
        start       = (cyc == 2);
        vec_wr_addr = 2'd0;
        vec_wr_data = 32'h99;
      end
      #1;
      if (done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (tx_i < COLS) begin
          chk({tag, "_tx_vld"},  32'(o_tvalid), 32'd1);
          chk({tag, "_tx_dat"},  o_tdata,       32'(tx_i + 1));
          chk({tag, "_tx_last"}, 32'(o_tlast),  32'(tx_i == COLS - 1));
          if (o_tready) tx_i++;
        end else begin
          chk({tag, "_tx_idle_vld"}, 32'(o_tvalid), 32'd0);
        end
        if (rx_i >= ROWS) chk({tag, "_rx_full_rdy"}, 32'(i_tready), 32'd0);
        if (i_tvalid && i_tready) rx_i++;
      end
      tick();
      cyc++;
    end
    start     = 1'b0;
    vec_wr_en = 1'b0;
    i_tvalid  = 1'b0;
    i_tlast   = 1'b0;
    o_tready  = 1'b1;
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_tx_count"},   32'(tx_i),     32'd4);
    chk({tag, "_rx_count"},   32'(rx_i),     32'd3);
    chk({tag, "_err"},        32'(err),      32'(exp_err));
    chk({tag, "_post_done"},  32'(done),     32'd0);
    chk({tag, "_post_busy"},  32'(busy),     32'd0);
    chk({tag, "_post_irdy"},  32'(i_tready), 32'd0);
    tick();
    chk({tag, "_single_done"}, 32'(done), 32'd0);
    for (int i = 0; i < ROWS; i++) begin
      res_rd_addr = 2'(i);
      #1;
      chk({tag, "_res"}, res_rd_data, base + 32'(i));
    end
  endtask

  initial begin
    rst         = 1'b0;
    vec_wr_en   = 1'b0;
    vec_wr_addr = '0;
    vec_wr_data = '0;
    start       = 1'b0;
    res_rd_addr = '0;
    o_tready    = 1'b0;
    i_tdata     = '0;
    i_tlast     = 1'b0;
    i_tvalid    = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b1;
    tick();
    write_vec();

    // Basic transaction: tx in cycles 1-4, results in cycles 5-7, done in cycle 8.
    o_tready = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_irdy_c1", 32'(i_tready), 32'd1);
    for (int k = 0; k < COLS; k++) begin
      chk("t1_tvalid", 32'(o_tvalid), 32'd1);
      chk("t1_tdata",  o_tdata,       32'(k + 1));
      chk("t1_tlast",  32'(o_tlast),  32'(k == COLS - 1));
      tick();
    end
    chk("t1_tvalid_c5", 32'(o_tvalid), 32'd0);
    chk("t1_done_c5",   32'(done),     32'd0);
    send_rx(32'd10, 1'b0);
    send_rx(32'd20, 1'b0);
    send_rx(32'd30, 1'b1);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    chk("t1_done_c8", 32'(done),     32'd1);
    chk("t1_irdy_c8", 32'(i_tready), 32'd0);
    tick();
    chk("t1_done_c9", 32'(done), 32'd0);
    chk("t1_busy_c9", 32'(busy), 32'd0);
    chk("t1_err",     32'(err),  32'd0);
    for (int i = 0; i < ROWS; i++) begin
      res_rd_addr = 2'(i);
      #1;
      chk("t1_res", res_rd_data, 32'(10 * (i + 1)));
    end

    // Stalled tx (ready 1,0,0 repeating): handshakes in cycles 1,4,7,10, rx in 1-3, done in 11.
    run_txn("stall", 1, 1, 1'b0, 32'd100, 1'b0, 1'b0, 11);
    // Results interleaved from cycle 2: tx and rx both finish in cycle 4, done in 5.
    run_txn("overlap", 0, 2, 1'b0, 32'd200, 1'b0, 1'b0, 5);
    // TLAST on result word 1: error after done, capture still completes.
    run_txn("frame", 0, 1, 1'b1, 32'd300, 1'b0, 1'b1, 5);

    // Reset asserted in cycle 2 of a transaction; the following start must clear err first.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_err_cleared", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_reset("midrst");
    rst = 1'b1;
    tick();
    write_vec();

    // Vector write and start during RUN are ignored; results 3-5, done in 6.
    run_txn("poke", 0, 3, 1'b0, 32'd400, 1'b1, 1'b0, 6);
    // Vector still {1,2,3,4}; results 6-8, done in 9.
    run_txn("after", 0, 6, 1'b0, 32'd500, 1'b0, 1'b0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
